id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage 32-bit RISC-V core, directly downstream of the decode control unit.
- Latches the decode-stage control bits, operands, immediate and register specifiers for the EX stage.
- Contains the load-use hazard detector whose hazard_stall output drives the control unit's block_control input and the PC / IF-ID write enables.
- Inserts bubbles on load-use stall or branch flush, and keeps saturating stall and flush event counters.

---
 rtl/core_pkg.sv | 28 ++
 rtl/sat_counter.sv | 22 ++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, ALUOp encodings and the decode control bundle.
package core_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Unsigned event counter that saturates at all-ones; clears on synchronous active-low reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!hold && inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating stall/flush event counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic             id_alusrc,
  input  logic             id_memtoreg,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_branch,
  input  logic [1:0]       id_aluop,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  output logic             hazard_stall,
  output logic             ex_valid,
  output logic             ex_alusrc,
  output logic             ex_memtoreg,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_branch,
  output logic [1:0]       ex_aluop,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  bubble;

  assign id_ctrl = '{alusrc:   id_alusrc,
                     memtoreg: id_memtoreg,
                     regwrite: id_regwrite,
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     branch:   id_branch,
                     aluop:    id_aluop};

  // Load-use: the load in EX writes a register the ID instruction reads; a flushed ID never stalls.
  assign hazard_stall = id_valid & ex_valid & ex_ctrl.memread & (ex_rd != REG_W'(0)) &
                        ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush;

  assign bubble = flush | hazard_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= BUBBLE;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= BUBBLE;
        ex_pc       <= '0;
        ex_rd1      <= '0;
        ex_rd2      <= '0;
        ex_imm      <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
        ex_funct3   <= '0;
        ex_funct7b5 <= 1'b0;
      end else begin
        ex_valid    <= id_valid;
        ex_ctrl     <= id_ctrl;
        ex_pc       <= id_pc;
        ex_rd1      <= id_rd1;
        ex_rd2      <= id_rd2;
        ex_imm      <= id_imm;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rd       <= id_rd;
        ex_funct3   <= id_funct3;
        ex_funct7b5 <= id_funct7b5;
      end
    end
  end

  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_branch   = ex_ctrl.branch;
  assign ex_aluop    = ex_ctrl.aluop;

  // hazard_stall already excludes flush, so the two counters never step together.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .inc   (hazard_stall),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .inc   (flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/hold/saturation cases plus random traffic.
module tb_id_ex_stage;

  localparam int unsigned CW  = 4;
  localparam int          MAXC = 15;

  typedef struct packed {
    logic        valid, alusrc, memtoreg, regwrite, memread, memwrite, branch;
    logic [1:0]  aluop;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        f7;
  } ex_t;

  typedef struct packed {
    logic rst_n, hold, flush;
    ex_t  id;
  } in_t;

  typedef struct packed {
    ex_t          ex;
    logic [CW-1:0] sc, fc;
    logic         hz;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n, hold, flush, id_valid;
  logic id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch;
  logic [1:0]  id_aluop;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7b5;
  logic hazard_stall, ex_valid;
  logic ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
  logic [1:0]  ex_aluop;
  logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic [CW-1:0] stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
    .id_aluop(id_aluop), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  rec_t sb_q[$];

  // Reference model state: what EX should hold, plus counter values.
  ex_t m_ex;
  int  m_sc, m_fc;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t s);
    rst_n = s.rst_n; hold = s.hold; flush = s.flush;
    id_valid = s.id.valid; id_alusrc = s.id.alusrc; id_memtoreg = s.id.memtoreg;
    id_regwrite = s.id.regwrite; id_memread = s.id.memread; id_memwrite = s.id.memwrite;
    id_branch = s.id.branch; id_aluop = s.id.aluop; id_pc = s.id.pc; id_rd1 = s.id.rd1;
    id_rd2 = s.id.rd2; id_imm = s.id.imm; id_rs1 = s.id.rs1; id_rs2 = s.id.rs2;
    id_rd = s.id.rd; id_funct3 = s.id.funct3; id_funct7b5 = s.id.f7;
  endtask

  function automatic ex_t rand_id();
    ex_t e;
    e.valid = ($urandom_range(0, 9) < 8);
    e.alusrc = 1'($urandom); e.memtoreg = 1'($urandom); e.regwrite = 1'($urandom);
    e.memread = 1'($urandom); e.memwrite = 1'($urandom); e.branch = 1'($urandom);
    e.aluop = 2'($urandom);
    e.pc = $urandom; e.rd1 = $urandom; e.rd2 = $urandom; e.imm = $urandom;
    e.rs1 = 5'($urandom_range(0, 3)); e.rs2 = 5'($urandom_range(0, 3));
    e.rd = 5'($urandom_range(0, 3));
    e.funct3 = 3'($urandom); e.f7 = 1'($urandom);
    return e;
  endfunction

  function automatic in_t mk(input logic r, input logic h, input logic f, input ex_t id);
    in_t s;
    s.rst_n = r; s.hold = h; s.flush = f; s.id = id;
    return s;
  endfunction

  // One clock: drive inputs, record expectation for this cycle, advance the model across the edge.
  task automatic cycle(input in_t s);
    rec_t r;
    bit   load_use;
    apply(s);
    load_use = s.id.valid && m_ex.valid && m_ex.memread && (m_ex.rd != 0) &&
               (m_ex.rd == s.id.rs1 || m_ex.rd == s.id.rs2) && !s.flush;
    r.ex = m_ex; r.sc = CW'(m_sc); r.fc = CW'(m_fc); r.hz = load_use;
    sb_q.push_back(r);
    if (!s.rst_n) begin
      m_ex = '0; m_sc = 0; m_fc = 0;
    end else if (s.hold) begin
      // everything frozen
    end else if (s.flush) begin
      m_ex = '0; m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
    end else if (load_use) begin
      m_ex = '0; m_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
    end else begin
      m_ex = s.id;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: once per cycle, away from the active edge, compare the DUT with the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      rec_t r;
      ex_t  act;
      r = sb_q.pop_front();
      act = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
             ex_aluop, ex_pc, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3,
             ex_funct7b5};
      check("ex_state", 256'(act), 256'(r.ex));
      check("counters", 256'({stall_cnt, flush_cnt}), 256'({r.sc, r.fc}));
      check("hazard_stall", 256'(hazard_stall), 256'(r.hz));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_t lw, add, e;
    m_ex = '0; m_sc = 0; m_fc = 0;
    // Reset for two cycles with random ID inputs.
    apply(mk(1'b0, 1'($urandom), 1'($urandom), rand_id()));
    @(posedge clk); #1;
    cycle(mk(1'b0, 1'($urandom), 1'($urandom), rand_id()));

    // Load-use: lw x5 then add with rs2=x5, held in ID for two cycles.
    lw = rand_id(); lw.valid = 1; lw.memread = 1; lw.memtoreg = 1; lw.regwrite = 1;
    lw.alusrc = 1; lw.memwrite = 0; lw.branch = 0; lw.aluop = 2'b00; lw.rd = 5'd5;
    lw.rs1 = 5'd2; lw.rs2 = 5'd0;
    add = rand_id(); add.valid = 1; add.memread = 0; add.alusrc = 0; add.regwrite = 1;
    add.aluop = 2'b10; add.rs1 = 5'd1; add.rs2 = 5'd5; add.rd = 5'd6;
    cycle(mk(1'b1, 1'b0, 1'b0, lw));
    cycle(mk(1'b1, 1'b0, 1'b0, add));
    cycle(mk(1'b1, 1'b0, 1'b0, add));
    cycle(mk(1'b1, 1'b0, 1'b0, add));

    // Load to x0 never stalls.
    lw.rd = 5'd0;
    cycle(mk(1'b1, 1'b0, 1'b0, lw));
    e = add; e.rs1 = 5'd0; e.rs2 = 5'd0;
    cycle(mk(1'b1, 1'b0, 1'b0, e));

    // Load-use condition with flush: flush wins.
    lw.rd = 5'd5;
    cycle(mk(1'b1, 1'b0, 1'b0, lw));
    cycle(mk(1'b1, 1'b0, 1'b1, add));

    // Hold for 3 cycles with changing inputs and flush high, then release with flush.
    cycle(mk(1'b1, 1'b0, 1'b0, lw));
    for (int i = 0; i < 3; i++) cycle(mk(1'b1, 1'b1, 1'b1, rand_id()));
    cycle(mk(1'b1, 1'b0, 1'b1, rand_id()));
    cycle(mk(1'b1, 1'b0, 1'b0, add));

    // Saturation: 20 consecutive flushes.
    for (int i = 0; i < 20; i++) cycle(mk(1'b1, 1'b0, 1'b1, rand_id()));
    check("flush_cnt_saturated", 256'(flush_cnt), 256'(MAXC));

    // Random traffic, with an occasional mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      cycle(mk(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 10), rand_id()));
    end

    @(negedge clk); #1;
    check("scoreboard_drained", 256'(sb_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
